instruction_fetch_unit: RTL and testbench

- Program sequencer directly upstream of `cpu`.
- Reads 16-bit machine-code words from an external synchronous program memory and drives `cpu.current_instruction`, one word at a time.
- Stops at the halt sentinel 16'hFFFF.
- Inserts NOPs while the tensor core is busy after a TENSOR_CORE_OPERATE.

---
 rtl/cpu_isa_pkg.sv | 36 +++
 rtl/instruction_fetch_unit.sv | 93 +++++++++
 tb/tb_instruction_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_isa_pkg.sv
// ISA constants and the fetch state encoding.
// Shared by the cpu, the instruction fetch unit and their benches.
package cpu_isa_pkg;

  localparam int BUS_WIDTH = 7;

  // Opcodes live in the top nibble of each machine-code word.
  localparam logic [3:0] NOP                 = 4'b0000;
  localparam logic [3:0] LOAD_IMMEDIATE      = 4'b0001;
  localparam logic [3:0] LOAD                = 4'b0010;
  localparam logic [3:0] STORE               = 4'b0011;
  localparam logic [3:0] ADD                 = 4'b0100;
  localparam logic [3:0] SUB                 = 4'b0101;
  localparam logic [3:0] MUL                 = 4'b0110;
  localparam logic [3:0] BITWISE_AND         = 4'b0111;
  localparam logic [3:0] BITWISE_OR          = 4'b1000;
  localparam logic [3:0] TENSOR_CORE_OPERATE = 4'b1001;
  localparam logic [3:0] JUMP                = 4'b1010;
  localparam logic [3:0] BRANCH_ZERO         = 4'b1011;
  localparam logic [3:0] COMPARE             = 4'b1100;
  localparam logic [3:0] MOVE                = 4'b1101;
  localparam logic [3:0] TENSOR_CORE_LOAD    = 4'b1110;
  localparam logic [3:0] TENSOR_CORE_READ    = 4'b1111;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;
  localparam logic [15:0] NOP_WORD  = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_TENSOR,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Program sequencer: fetches words from a synchronous program ROM and issues
// them to the cpu one every two cycles, stalling behind tensor-core operations.
module instruction_fetch_unit #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int PROGRAM_DEPTH     = 1024,
  parameter logic [INSTRUCTION_WIDTH-1:0] HALT_WORD = 16'hFFFF,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_WORD  = 16'h0000,
  localparam int ADDR_W = $clog2(PROGRAM_DEPTH)
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         start_in,
  input  logic                         tensor_core_done_in,
  output logic [ADDR_W-1:0]            memory_address_out,
  input  logic [INSTRUCTION_WIDTH-1:0] memory_data_in,
  output logic [INSTRUCTION_WIDTH-1:0] current_instruction,
  output logic                         instruction_valid_out,
  output logic [ADDR_W-1:0]            program_counter_out,
  output logic                         busy_out,
  output logic                         halted_out,
  output logic                         overrun_out
);
  import cpu_isa_pkg::*;

  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(PROGRAM_DEPTH - 1);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              wait_first;
  logic [3:0]        opcode;

  assign opcode              = memory_data_in[INSTRUCTION_WIDTH-1 -: 4];
  assign memory_address_out  = pc;
  assign program_counter_out = pc;
  assign busy_out            = (state == FETCH) || (state == ISSUE) || (state == WAIT_TENSOR);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state                 <= IDLE;
      pc                    <= '0;
      wait_first            <= 1'b0;
      current_instruction   <= NOP_WORD;
      instruction_valid_out <= 1'b0;
      halted_out            <= 1'b0;
      overrun_out           <= 1'b0;
    end else begin
      // Every cycle that does not issue a real word drives a NOP.
      current_instruction   <= NOP_WORD;
      instruction_valid_out <= 1'b0;
      case (state)
        IDLE, HALTED: begin
          if (start_in) begin
            state      <= FETCH;
            pc         <= '0;
            halted_out <= 1'b0;
          end
        end
        FETCH: state <= ISSUE;
        ISSUE: begin
          if (memory_data_in == HALT_WORD) begin
            state      <= HALTED;
            halted_out <= 1'b1;
          end else begin
            current_instruction   <= memory_data_in;
            instruction_valid_out <= 1'b1;
            if (pc == PC_LAST) begin
              // Ran off the end of program memory: stop instead of wrapping.
              state       <= HALTED;
              halted_out  <= 1'b1;
              overrun_out <= 1'b1;
            end else begin
              pc <= pc + ADDR_W'(1);
              if (opcode == TENSOR_CORE_OPERATE) begin
                state      <= WAIT_TENSOR;
                wait_first <= 1'b1;
              end else begin
                state <= FETCH;
              end
            end
          end
        end
        WAIT_TENSOR: begin
          // The core's done flag may still be stale from the previous op
          // during the first wait cycle, so it is only trusted afterwards.
          wait_first <= 1'b0;
          if (!wait_first && tensor_core_done_in) state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit: a timing model
// predicts every issued word and halt event; a monitor pops and compares.
module tb_instruction_fetch_unit;

  localparam int DN = 8192;

  typedef struct {
    logic [15:0] word;
    int          at;
  } iss_t;

  typedef struct {
    int   at;
    int   pc;
    logic ovr;
  } hlt_t;

  logic clk = 1'b0;
  logic reset_in, start_in, done, sel;
  int   cyc = 0;
  int   checks = 0, failures = 0;

  logic [15:0] rom_a [0:1023];
  logic [15:0] rom_b [0:3];
  logic        done_at [0:DN-1];

  iss_t exp_q[$];
  hlt_t halt_q[$];
  logic m_ovr;
  logic halted_q = 1'b0;

  logic [9:0]  addr_a, pc_a;
  logic [1:0]  addr_b, pc_b;
  logic [15:0] mem_a, mem_b, cur_a, cur_b;
  logic        valid_a, valid_b, busy_a, busy_b, halted_a, halted_b, ovr_a, ovr_b;

  instruction_fetch_unit dut_a (
    .clock_in(clk), .reset_in(reset_in), .start_in(start_in & ~sel),
    .tensor_core_done_in(done), .memory_address_out(addr_a), .memory_data_in(mem_a),
    .current_instruction(cur_a), .instruction_valid_out(valid_a),
    .program_counter_out(pc_a), .busy_out(busy_a), .halted_out(halted_a),
    .overrun_out(ovr_a)
  );

  instruction_fetch_unit #(.PROGRAM_DEPTH(4)) dut_b (
    .clock_in(clk), .reset_in(reset_in), .start_in(start_in & sel),
    .tensor_core_done_in(done), .memory_address_out(addr_b), .memory_data_in(mem_b),
    .current_instruction(cur_b), .instruction_valid_out(valid_b),
    .program_counter_out(pc_b), .busy_out(busy_b), .halted_out(halted_b),
    .overrun_out(ovr_b)
  );

  // Synchronous program ROMs: data appears one cycle after the address.
  always @(posedge clk) begin
    mem_a <= rom_a[addr_a];
    mem_b <= rom_b[addr_b];
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // done_at[e] is the value of tensor_core_done_in seen at rising edge e.
  always @(negedge clk) done = done_at[(cyc + 1) % DN];

  wire        mon_valid  = sel ? valid_b  : valid_a;
  wire [15:0] mon_instr  = sel ? cur_b    : cur_a;
  wire [9:0]  mon_pc     = sel ? 10'(pc_b) : pc_a;
  wire [9:0]  mon_addr   = sel ? 10'(addr_b) : addr_a;
  wire        mon_halted = sel ? halted_b : halted_a;
  wire        mon_ovr    = sel ? ovr_b    : ovr_a;
  wire        mon_busy   = sel ? busy_b   : busy_a;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the next predicted issue, at the
  // predicted edge; idle cycles must show NOP; each halt must match the model.
  always @(negedge clk) begin
    iss_t e;
    hlt_t h;
    if (!reset_in) begin
      if (mon_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", int'(mon_instr), -1);
        end else begin
          e = exp_q.pop_front();
          chk("issue_word", int'(mon_instr), int'(e.word));
          chk("issue_cycle", cyc, e.at);
        end
      end else begin
        chk("nop_when_idle", int'(mon_instr), 0);
      end
      if (mon_halted && !halted_q) begin
        if (halt_q.size() == 0) begin
          chk("unexpected_halt", cyc, -1);
        end else begin
          h = halt_q.pop_front();
          chk("halt_cycle", cyc, h.at);
          chk("halt_pc", int'(mon_pc), h.pc);
          chk("halt_overrun", int'(mon_ovr), int'(h.ovr));
          chk("halt_not_busy", int'(mon_busy), 0);
        end
      end
    end
    halted_q = mon_halted;
  end

  // Reference model: walks the program from address 0 and predicts the edge
  // at which each word becomes visible. t is the edge at which a fetch begins;
  // fetch + issue take two cycles. After a tensor op, done counts from the
  // second wait cycle, and the next fetch begins once it has been seen high.
  task automatic model_run(input int s);
    int unsigned a = 0;
    int t = s;
    int dep = sel ? 4 : 1024;
    int j;
    logic [15:0] w;
    forever begin
      w = sel ? rom_b[a[1:0]] : rom_a[a[9:0]];
      if (w == 16'hFFFF) begin
        halt_q.push_back('{at: t + 2, pc: int'(a), ovr: m_ovr});
        break;
      end
      exp_q.push_back('{word: w, at: t + 2});
      if (int'(a) == dep - 1) begin
        m_ovr = 1'b1;
        halt_q.push_back('{at: t + 2, pc: int'(a), ovr: 1'b1});
        break;
      end
      a++;
      if (w[15:12] == 4'h9) begin
        j = 2;
        while (j < 500 && !done_at[(t + 2 + j) % DN]) j++;
        t = t + 2 + j;
      end else begin
        t = t + 2;
      end
    end
  endtask

  // mode 0: always high, 1: high only after edge base, 2: random, 3: never
  task automatic set_done(input int mode, input int base);
    for (int e = cyc + 2; e < DN; e++)
      case (mode)
        0:       done_at[e] = 1'b1;
        1:       done_at[e] = (e > base);
        2:       done_at[e] = ($urandom_range(0, 2) == 0);
        default: done_at[e] = 1'b0;
      endcase
  endtask

  task automatic start_run(input int mode, input int wait_len, output int s);
    @(negedge clk);
    s = cyc + 1;
    set_done(mode, s + 2 + wait_len);
    start_in = 1'b1;
    model_run(s);
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_in = 1'b1;
    exp_q.delete();
    halt_q.delete();
    m_ovr = 1'b0;
    @(negedge clk);
    reset_in = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || halt_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size() + halt_q.size(), 0);
    exp_q.delete();
    halt_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic load_a(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    rom_a[0] = w0;
    rom_a[1] = w1;
    rom_a[2] = w2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, len;
    logic [15:0] w;
    sel = 1'b0; reset_in = 1'b1; start_in = 1'b0; m_ovr = 1'b0;
    for (int i = 0; i < DN; i++) done_at[i] = 1'b0;
    for (int i = 0; i < 1024; i++) rom_a[i] = 16'hFFFF;
    for (int i = 0; i < 4; i++) rom_b[i] = 16'(i + 1);
    repeat (3) @(negedge clk);
    reset_in = 1'b0;

    chk("reset_instr", int'(cur_a), 0);
    chk("reset_valid", int'(valid_a), 0);
    chk("reset_halted", int'(halted_a), 0);
    chk("reset_overrun", int'(ovr_a), 0);
    chk("reset_pc", int'(pc_a), 0);
    chk("reset_addr", int'(addr_a), 0);
    chk("reset_busy", int'(busy_a), 0);

    // Straight-line program ending in the halt word.
    load_a(16'h2123, 16'h3045, 16'hFFFF);
    start_run(3, 0, s);
    drain(100);

    // Tensor op with done low for 10 cycles, then with done always high.
    load_a(16'h9000, 16'h2011, 16'hFFFF);
    start_run(1, 10, s);
    drain(100);
    start_run(0, 0, s);
    drain(100);

    // Four-word memory without a halt word: overrun, then a sticky rerun.
    apply_reset();
    sel = 1'b1;
    apply_reset();
    start_run(3, 0, s);
    drain(100);
    start_run(3, 0, s);
    drain(100);
    chk("overrun_sticky", int'(ovr_b), 1);
    chk("overrun_pc", int'(pc_b), 3);

    // Reset in the middle of a tensor wait, then a clean restart.
    sel = 1'b0;
    apply_reset();
    load_a(16'h9000, 16'h2011, 16'hFFFF);
    start_run(3, 0, s);
    while (cyc < s + 6) @(negedge clk);
    @(negedge clk);
    reset_in = 1'b1;
    exp_q.delete();
    halt_q.delete();
    m_ovr = 1'b0;
    @(negedge clk);
    chk("midreset_busy", int'(busy_a), 0);
    chk("midreset_pc", int'(pc_a), 0);
    chk("midreset_instr", int'(cur_a), 0);
    chk("midreset_valid", int'(valid_a), 0);
    reset_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_still_idle", int'(busy_a), 0);
    start_run(0, 0, s);
    drain(100);

    // Extra start pulses while busy must not disturb the run.
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'h9 || w[15:12] == 4'hF) w[15:12] = 4'h3;
      rom_a[i] = w;
    end
    rom_a[8] = 16'hFFFF;
    start_run(3, 0, s);
    for (int k = 3; k <= 9; k += 3) begin
      while (cyc < s + k - 1) @(negedge clk);
      start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
    end
    drain(100);
    chk("midstart_pc", int'(mon_pc), 8);

    // Random programs with random tensor-done timing.
    for (int it = 0; it < 12; it++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) w[15:12] = 4'h9;
        if (w == 16'hFFFF) w = 16'h1234;
        rom_a[i] = w;
      end
      rom_a[len] = 16'hFFFF;
      start_run(2, 0, s);
      drain(600);
      chk("random_halted", int'(halted_a), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
